// File: rtl/alu_writeback_unit.sv
// Hack execute/writeback stage: updates A/D/PC on accept, one data-memory write per M-dest instruction.
// Zero-cycle accept; an M write stalls intake (instr_ready=0) until mem_wr_ready. WB_RETIRE_CNT_EN adds retired_count.
module alu_writeback_unit #(
    parameter int                 DATA_WIDTH = 16,
    parameter int                 PC_WIDTH   = 15,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [15:0]           instr,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_zr,
    input  logic                  alu_ng,
    output logic [DATA_WIDTH-1:0] a_reg,
    output logic [DATA_WIDTH-1:0] d_reg,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  mem_wr_valid,
    input  logic                  mem_wr_ready,
    output logic [PC_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]           retired_count
`endif
);

    typedef enum logic {READY, WR_WAIT} state_t;

    state_t              state;
    logic                accept;
    logic                is_c;
    logic                take;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] a_target;
    logic                unused_instr_bits;

    assign instr_ready  = (state == READY);
    assign mem_wr_valid = (state == WR_WAIT);
    assign accept       = instr_valid & instr_ready;
    assign is_c         = instr[15];
    assign pc_inc       = pc + PC_WIDTH'(1);
    assign a_target     = a_reg[PC_WIDTH-1:0];
    // Comp bits are consumed by the upstream ALU, not here.
    assign unused_instr_bits = ^instr[14:6];

    always_comb begin
        take = (instr[2] & alu_ng) | (instr[1] & alu_zr) | (instr[0] & ~alu_ng & ~alu_zr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= READY;
            a_reg     <= '0;
            d_reg     <= '0;
            pc        <= RESET_PC;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                READY: begin
                    if (accept) begin
                        if (!is_c) begin
                            a_reg <= DATA_WIDTH'(instr);
                            pc    <= pc_inc;
                        end else begin
                            // Jump target and write address both use the pre-edge A value.
                            pc <= take ? a_target : pc_inc;
                            if (instr[5]) a_reg <= alu_out;
                            if (instr[4]) d_reg <= alu_out;
                            if (instr[3]) begin
                                mem_addr  <= a_target;
                                mem_wdata <= alu_out;
                                state     <= WR_WAIT;
                            end
                        end
                    end
                end
                WR_WAIT: begin
                    if (mem_wr_ready) state <= READY;
                end
                default: state <= READY;
            endcase
        end
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)       retired_count <= '0;
        else if (accept) retired_count <= retired_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_alu_writeback_unit.sv
// Bench for alu_writeback_unit: reference model of A/D/PC plus a queue of expected memory writes.
module tb_alu_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic [15:0] a_reg;
    logic [15:0] d_reg;
    logic [14:0] pc;
    logic        mem_wr_valid;
    logic        mem_wr_ready;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retired_count;
`endif

    alu_writeback_unit dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .alu_out      (alu_out),
        .alu_zr       (alu_zr),
        .alu_ng       (alu_ng),
        .a_reg        (a_reg),
        .d_reg        (d_reg),
        .pc           (pc),
        .mem_wr_valid (mem_wr_valid),
        .mem_wr_ready (mem_wr_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retired_count(retired_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [14:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         wq[$];
    logic [15:0] exp_a;
    logic [15:0] exp_d;
    logic [14:0] exp_pc;
    int unsigned exp_ret;
    int          checks   = 0;
    int          failures = 0;

    // Presents one instruction for exactly one clock edge and advances the reference model.
    task automatic issue(input logic [15:0] ins, input logic [15:0] alu, input logic zr, input logic ng);
        logic [15:0] old_a;
        logic        tk;
        @(negedge clk);
        instr = ins; alu_out = alu; alu_zr = zr; alu_ng = ng; instr_valid = 1'b1;
        old_a = exp_a;
        if (!ins[15]) begin
            exp_a  = ins;
            exp_pc = exp_pc + 15'd1;
        end else begin
            tk = (ins[2] & ng) | (ins[1] & zr) | (ins[0] & ~ng & ~zr);
            exp_pc = tk ? old_a[14:0] : exp_pc + 15'd1;
            if (ins[5]) exp_a = alu;
            if (ins[4]) exp_d = alu;
            if (ins[3]) wq.push_back({old_a[14:0], alu});
        end
        exp_ret++;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        exp_a = '0; exp_d = '0; exp_pc = '0; exp_ret = 0;
        wq.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (a_reg !== 16'h0) begin failures++; $display("FAIL reset_a got=%h exp=0", a_reg); end
        checks++; if (d_reg !== 16'h0) begin failures++; $display("FAIL reset_d got=%h exp=0", d_reg); end
        checks++; if (pc !== 15'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc); end
        checks++; if (mem_wr_valid !== 1'b0 || instr_ready !== 1'b1) begin
            failures++; $display("FAIL reset_hs got valid=%b ready=%b exp valid=0 ready=1", mem_wr_valid, instr_ready); end
        checks++; if (mem_addr !== 15'h0 || mem_wdata !== 16'h0) begin
            failures++; $display("FAIL reset_mem got addr=%h data=%h exp 0/0", mem_addr, mem_wdata); end
    endtask

    task automatic test_a_instr();
        issue(16'h1234, 16'h0, 1'b0, 1'b0);
        checks++; if (a_reg !== 16'h1234) begin failures++; $display("FAIL a_instr_a got=%h exp=1234", a_reg); end
        checks++; if (pc !== 15'd1) begin failures++; $display("FAIL a_instr_pc got=%h exp=1", pc); end
        checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL a_instr_ready got=%b exp=1", instr_ready); end
    endtask

    task automatic test_c_dest();
        mem_wr_ready = 1'b1;
        issue(16'hEC10, 16'h00FF, 1'b0, 1'b0);
        checks++; if (d_reg !== 16'h00FF) begin failures++; $display("FAIL dest_d got=%h exp=00ff", d_reg); end
        checks++; if (a_reg !== 16'h1234) begin failures++; $display("FAIL dest_a_kept got=%h exp=1234", a_reg); end
        checks++; if (pc !== 15'd2) begin failures++; $display("FAIL dest_pc got=%h exp=2", pc); end
        checks++; if (mem_wr_valid !== 1'b0) begin failures++; $display("FAIL dest_no_wr got=%b exp=0", mem_wr_valid); end
        mem_wr_ready = 1'b0;
    endtask

    task automatic test_mem_write();
        wr_t e;
        int  held = 0;
        issue(16'h0010, 16'h0, 1'b0, 1'b0);
        issue(16'hE308, 16'hBEEF, 1'b0, 1'b0);
        alu_out = 16'h0000;
        e = (wq.size() != 0) ? wq[0] : '0;
        checks++; if (e.addr !== 15'h0010 || e.data !== 16'hBEEF) begin
            failures++; $display("FAIL mw_model got addr=%h data=%h exp 0010/beef", e.addr, e.data); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_wr_valid === 1'b1) held++;
            checks++; if (instr_ready !== 1'b0 || mem_addr !== e.addr || mem_wdata !== e.data) begin
                failures++; $display("FAIL mw_hold%0d got rdy=%b addr=%h data=%h exp 0/%h/%h", i, instr_ready, mem_addr, mem_wdata, e.addr, e.data); end
            if (i == 3) mem_wr_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        mem_wr_ready = 1'b0;
        if (wq.size() != 0) void'(wq.pop_front());
        checks++; if (held !== 4) begin failures++; $display("FAIL mw_valid_cycles got=%0d exp=4", held); end
        checks++; if (mem_wr_valid !== 1'b0 || instr_ready !== 1'b1) begin
            failures++; $display("FAIL mw_done got valid=%b ready=%b exp 0/1", mem_wr_valid, instr_ready); end
        checks++; if (pc !== exp_pc) begin failures++; $display("FAIL mw_pc got=%h exp=%h", pc, exp_pc); end
    endtask

    task automatic test_jumps();
        issue(16'h0020, 16'h0, 1'b0, 1'b0);
        issue(16'hE304, 16'hFFFF, 1'b0, 1'b1);
        checks++; if (pc !== 15'h0020) begin failures++; $display("FAIL jlt_taken got=%h exp=0020", pc); end
        issue(16'h0020, 16'h0, 1'b0, 1'b0);
        issue(16'hE304, 16'h0000, 1'b1, 1'b0);
        checks++; if (pc !== 15'h0022) begin failures++; $display("FAIL jlt_not_taken got=%h exp=0022", pc); end
        issue(16'hE302, 16'h0000, 1'b1, 1'b0);
        checks++; if (pc !== exp_pc || pc !== 15'h0020) begin failures++; $display("FAIL jeq_taken got=%h exp=0020", pc); end
        issue(16'hEA87, 16'h0005, 1'b0, 1'b0);
        checks++; if (pc !== 15'h0020) begin failures++; $display("FAIL jmp got=%h exp=0020", pc); end
    endtask

    task automatic test_wrap_and_am();
        wr_t e;
        issue(16'h7FFF, 16'h0, 1'b0, 1'b0);
        issue(16'hEA87, 16'h0000, 1'b1, 1'b0);
        issue(16'h0005, 16'h0, 1'b0, 1'b0);
        checks++; if (pc !== 15'h0) begin failures++; $display("FAIL pc_wrap got=%h exp=0", pc); end
        issue(16'hEFE8, 16'h0009, 1'b0, 1'b0);
        e = (wq.size() != 0) ? wq[0] : '0;
        checks++; if (a_reg !== 16'h0009) begin failures++; $display("FAIL am_a got=%h exp=0009", a_reg); end
        checks++; if (mem_wr_valid !== 1'b1 || mem_addr !== 15'h5 || mem_wdata !== 16'h9 || e.addr !== 15'h5) begin
            failures++; $display("FAIL am_write got v=%b addr=%h data=%h exp 1/0005/0009", mem_wr_valid, mem_addr, mem_wdata); end
        @(negedge clk);
        mem_wr_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_wr_ready = 1'b0;
        if (wq.size() != 0) void'(wq.pop_front());
        checks++; if (mem_wr_valid !== 1'b0 || instr_ready !== 1'b1) begin
            failures++; $display("FAIL am_zero_wait got valid=%b ready=%b exp 0/1", mem_wr_valid, instr_ready); end
    endtask

    task automatic test_back_to_back();
        wr_t e;
        issue(16'h0100, 16'h0, 1'b0, 1'b0);
        issue(16'hE318, 16'h0ABC, 1'b0, 1'b0);
        e = (wq.size() != 0) ? wq[0] : '0;
        @(negedge clk);
        instr = 16'h0AAA; instr_valid = 1'b1; mem_wr_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (a_reg !== exp_a || pc !== exp_pc || d_reg !== 16'h0ABC) begin
            failures++; $display("FAIL stall_ignore got a=%h pc=%h d=%h exp %h/%h/0abc", a_reg, pc, d_reg, exp_a, exp_pc); end
        @(negedge clk);
        mem_wr_ready = 1'b1;
        checks++; if (mem_wr_valid !== 1'b1 || mem_addr !== e.addr || mem_wdata !== e.data) begin
            failures++; $display("FAIL b2b_write got v=%b addr=%h data=%h exp 1/%h/%h", mem_wr_valid, mem_addr, mem_wdata, e.addr, e.data); end
        @(posedge clk);
        #1;
        mem_wr_ready = 1'b0;
        if (wq.size() != 0) void'(wq.pop_front());
        checks++; if (a_reg !== 16'h0100 || instr_ready !== 1'b1) begin
            failures++; $display("FAIL b2b_release got a=%h rdy=%b exp 0100/1", a_reg, instr_ready); end
        issue(16'h0AAA, 16'h0, 1'b0, 1'b0);
        checks++; if (a_reg !== 16'h0AAA || pc !== exp_pc) begin
            failures++; $display("FAIL b2b_held got a=%h pc=%h exp 0aaa/%h", a_reg, pc, exp_pc); end
        for (int i = 0; i < 4; i++) begin
            issue(16'h0300 + 16'(i), 16'h0, 1'b0, 1'b0);
            checks++; if (a_reg !== exp_a || pc !== exp_pc || instr_ready !== 1'b1) begin
                failures++; $display("FAIL burst%0d got a=%h pc=%h exp %h/%h", i, a_reg, pc, exp_a, exp_pc); end
        end
    endtask

    task automatic test_reset_mid_write();
        issue(16'h0040, 16'h0, 1'b0, 1'b0);
        issue(16'hE308, 16'h1111, 1'b0, 1'b0);
        checks++; if (mem_wr_valid !== 1'b1) begin failures++; $display("FAIL rmw_pending got=%b exp=1", mem_wr_valid); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (mem_wr_valid !== 1'b0 || instr_ready !== 1'b1 || pc !== 15'h0) begin
            failures++; $display("FAIL rmw_reset got v=%b rdy=%b pc=%h exp 0/1/0", mem_wr_valid, instr_ready, pc); end
        @(negedge clk);
        reset = 1'b0;
        exp_a = '0; exp_d = '0; exp_pc = '0; exp_ret = 0;
        wq.delete();
    endtask

`ifdef WB_RETIRE_CNT_EN
    task automatic test_retire();
        do_reset();
        checks++; if (retired_count !== 32'd0) begin failures++; $display("FAIL ret_reset got=%0d exp=0", retired_count); end
        issue(16'h0001, 16'h0, 1'b0, 1'b0);
        issue(16'hEC10, 16'h0007, 1'b0, 1'b0);
        issue(16'h0002, 16'h0, 1'b0, 1'b0);
        checks++; if (retired_count !== 32'd3 || retired_count !== 32'(exp_ret)) begin
            failures++; $display("FAIL ret_count got=%0d exp=3", retired_count); end
        do_reset();
        checks++; if (retired_count !== 32'd0) begin failures++; $display("FAIL ret_clear got=%0d exp=0", retired_count); end
    endtask
`endif

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr = '0; alu_out = '0;
        alu_zr = 1'b0; alu_ng = 1'b0; mem_wr_ready = 1'b0;
        exp_a = '0; exp_d = '0; exp_pc = '0; exp_ret = 0;
        test_reset();
        test_a_instr();
        test_c_dest();
        test_mem_write();
        test_jumps();
        test_wrap_and_am();
        test_back_to_back();
        test_reset_mid_write();
`ifdef WB_RETIRE_CNT_EN
        test_retire();
`endif
        checks++; if (wq.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", wq.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
